// File: rtl/soma_if.sv
// Handshake and data bundle between the alignment stage and the add/normalize stage.
interface soma_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic             sinal_A;
    logic             sinal_B;
    logic [EXP_W-1:0] expoente;
    logic [MAN_W-1:0] mantissa_A;
    logic [MAN_W-1:0] mantissa_B_ajustado;
    logic             out_valid;
    logic             out_ready;
    logic             sinal_R;
    logic [EXP_W-1:0] expoente_R;
    logic [MAN_W-1:0] mantissa_R;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, sinal_A, sinal_B, expoente, mantissa_A, mantissa_B_ajustado, out_ready,
        input  in_ready, out_valid, sinal_R, expoente_R, mantissa_R, overflow, zero
    );

    modport slave (
        input  in_valid, sinal_A, sinal_B, expoente, mantissa_A, mantissa_B_ajustado, out_ready,
        output in_ready, out_valid, sinal_R, expoente_R, mantissa_R, overflow, zero
    );
endinterface

// File: rtl/soma_normaliza.sv
// Half-precision magnitude add/sub followed by one-bit-per-cycle renormalization.
// Operands share one exponent (B already aligned to A). One operation in flight.
module soma_normaliza #(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 11,
    parameter int EXP_MAX = 31
) (
    input  logic clk,
    input  logic rst_n,
    soma_if.slave bus
);
    localparam logic [EXP_W:0] EXP_SAT  = (EXP_W + 1)'(EXP_MAX);
    localparam logic [EXP_W:0] EXP_ZERO = {(EXP_W + 1){1'b0}};
    localparam logic [EXP_W:0] EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [MAN_W:0] SUM_ZERO = {(MAN_W + 1){1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOMA = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_r, state_nxt_s;

    // Captured operands
    logic             sa_r, sa_nxt_s;
    logic             sb_r, sb_nxt_s;
    logic [EXP_W-1:0] exp_in_r, exp_in_nxt_s;
    logic [MAN_W-1:0] a_r, a_nxt_s;
    logic [MAN_W-1:0] b_r, b_nxt_s;

    // Working result: exponent and mantissa carry one guard bit each
    logic             sign_r, sign_nxt_s;
    logic [EXP_W:0]   exp_r, exp_nxt_s;
    logic [MAN_W:0]   mant_r, mant_nxt_s;
    logic             ovf_r, ovf_nxt_s;
    logic             zero_r, zero_nxt_s;

    // Registered outputs
    logic             in_ready_r, in_ready_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic             sinal_R_r, sinal_R_nxt_s;
    logic [EXP_W-1:0] expoente_R_r, expoente_R_nxt_s;
    logic [MAN_W-1:0] mantissa_R_r, mantissa_R_nxt_s;
    logic             overflow_r, overflow_nxt_s;
    logic             zero_out_r, zero_out_nxt_s;

    // Arithmetic helpers
    logic [MAN_W:0]   sum_s;
    logic             sum_sign_s;
    logic [EXP_W:0]   exp_inc_s;
    logic [MAN_W:0]   mant_shl_s;
    logic [EXP_W:0]   exp_dec_s;

    // Signed-magnitude add/sub of the captured mantissas
    always_comb begin
        sum_s      = SUM_ZERO;
        sum_sign_s = 1'b0;
        if (sa_r == sb_r) begin
            sum_s      = {1'b0, a_r} + {1'b0, b_r};
            sum_sign_s = sa_r;
        end else if (a_r > b_r) begin
            sum_s      = {1'b0, a_r} - {1'b0, b_r};
            sum_sign_s = sa_r;
        end else if (b_r > a_r) begin
            sum_s      = {1'b0, b_r} - {1'b0, a_r};
            sum_sign_s = sb_r;
        end else begin
            // Exact cancellation yields +0
            sum_s      = SUM_ZERO;
            sum_sign_s = 1'b0;
        end
    end

    // Exponent increment/decrement and the one-bit left shift used while normalizing
    always_comb begin
        exp_inc_s  = {1'b0, exp_in_r} + EXP_ONE;
        exp_dec_s  = exp_r - EXP_ONE;
        mant_shl_s = {mant_r[MAN_W-1:0], 1'b0};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; NORM looks ahead at the shifted value so it exits on the cycle that finishes
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    state_nxt_s = SOMA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SOMA: begin
                if (sum_s == SUM_ZERO || sum_s[MAN_W] || sum_s[MAN_W-1]) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = NORM;
                end
            end
            NORM: begin
                if (mant_r[MAN_W-1] || exp_r == EXP_ZERO) begin
                    state_nxt_s = DONE;
                end else if (mant_shl_s[MAN_W-1] || exp_dec_s == EXP_ZERO) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = NORM;
                end
            end
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath next values: capture, sum/overflow resolution, normalization shift
    always_comb begin
        sa_nxt_s     = sa_r;
        sb_nxt_s     = sb_r;
        exp_in_nxt_s = exp_in_r;
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        sign_nxt_s   = sign_r;
        exp_nxt_s    = exp_r;
        mant_nxt_s   = mant_r;
        ovf_nxt_s    = ovf_r;
        zero_nxt_s   = zero_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    sa_nxt_s     = bus.sinal_A;
                    sb_nxt_s     = bus.sinal_B;
                    exp_in_nxt_s = bus.expoente;
                    a_nxt_s      = bus.mantissa_A;
                    b_nxt_s      = bus.mantissa_B_ajustado;
                    sign_nxt_s   = 1'b0;
                    exp_nxt_s    = EXP_ZERO;
                    mant_nxt_s   = SUM_ZERO;
                    ovf_nxt_s    = 1'b0;
                    zero_nxt_s   = 1'b0;
                end else begin
                    zero_nxt_s   = zero_r;
                end
            end
            SOMA: begin
                sign_nxt_s = sum_sign_s;
                if (sum_s == SUM_ZERO) begin
                    zero_nxt_s = 1'b1;
                    exp_nxt_s  = EXP_ZERO;
                    mant_nxt_s = SUM_ZERO;
                end else if (sum_s[MAN_W]) begin
                    if (exp_inc_s >= EXP_SAT) begin
                        ovf_nxt_s  = 1'b1;
                        exp_nxt_s  = EXP_SAT;
                        mant_nxt_s = SUM_ZERO;
                    end else begin
                        exp_nxt_s  = exp_inc_s;
                        mant_nxt_s = {1'b0, sum_s[MAN_W:1]};
                    end
                end else begin
                    exp_nxt_s  = {1'b0, exp_in_r};
                    mant_nxt_s = sum_s;
                end
            end
            NORM: begin
                if (!mant_r[MAN_W-1] && exp_r != EXP_ZERO) begin
                    mant_nxt_s = mant_shl_s;
                    exp_nxt_s  = exp_dec_s;
                end else begin
                    mant_nxt_s = mant_r;
                end
            end
            DONE: begin
                mant_nxt_s = mant_r;
            end
            default: begin
                mant_nxt_s = mant_r;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            exp_in_r <= {EXP_W{1'b0}};
            a_r      <= {MAN_W{1'b0}};
            b_r      <= {MAN_W{1'b0}};
            sign_r   <= 1'b0;
            exp_r    <= EXP_ZERO;
            mant_r   <= SUM_ZERO;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            sa_r     <= sa_nxt_s;
            sb_r     <= sb_nxt_s;
            exp_in_r <= exp_in_nxt_s;
            a_r      <= a_nxt_s;
            b_r      <= b_nxt_s;
            sign_r   <= sign_nxt_s;
            exp_r    <= exp_nxt_s;
            mant_r   <= mant_nxt_s;
            ovf_r    <= ovf_nxt_s;
            zero_r   <= zero_nxt_s;
        end
    end

    // Output next values: result presented from the second DONE cycle, flags cleared on hand-off
    always_comb begin
        in_ready_nxt_s   = (state_nxt_s == IDLE);
        out_valid_nxt_s  = (state_r == DONE) && (state_nxt_s == DONE);
        sinal_R_nxt_s    = sinal_R_r;
        expoente_R_nxt_s = expoente_R_r;
        mantissa_R_nxt_s = mantissa_R_r;
        overflow_nxt_s   = 1'b0;
        zero_out_nxt_s   = 1'b0;
        if (out_valid_nxt_s) begin
            sinal_R_nxt_s    = sign_r;
            expoente_R_nxt_s = exp_r[EXP_W-1:0];
            mantissa_R_nxt_s = mant_r[MAN_W-1:0];
            overflow_nxt_s   = ovf_r;
            zero_out_nxt_s   = zero_r;
        end else begin
            overflow_nxt_s   = 1'b0;
            zero_out_nxt_s   = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            sinal_R_r    <= 1'b0;
            expoente_R_r <= {EXP_W{1'b0}};
            mantissa_R_r <= {MAN_W{1'b0}};
            overflow_r   <= 1'b0;
            zero_out_r   <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            sinal_R_r    <= sinal_R_nxt_s;
            expoente_R_r <= expoente_R_nxt_s;
            mantissa_R_r <= mantissa_R_nxt_s;
            overflow_r   <= overflow_nxt_s;
            zero_out_r   <= zero_out_nxt_s;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.sinal_R    = sinal_R_r;
    assign bus.expoente_R = expoente_R_r;
    assign bus.mantissa_R = mantissa_R_r;
    assign bus.overflow   = overflow_r;
    assign bus.zero       = zero_out_r;
endmodule
